// File: rtl/cp0_timer_if.sv
// Bridge-side register bus for the CP0 countdown timer: word address, write strobe,
// write/read data, and the interrupt line toward CP0 HWInt.
interface cp0_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/cp0_timer.sv
// Programmable countdown timer (one-shot / periodic) with maskable interrupt for CP0.
// Optional prescaler at addr3 enabled by defining CP0_TIMER_PRESCALE_EN.
module cp0_timer #(
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input logic         clk,
  input logic         reset,
  cp0_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        step;

`ifdef CP0_TIMER_PRESCALE_EN
  logic [7:0]  prescale;
  logic [7:0]  pcnt;
  assign step = (pcnt == prescale);
`else
  assign step = 1'b1;
`endif

  assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
  assign preset_wr = bus.we && (bus.addr == 2'd1);

  // Later assignments win: FSM expiry set overrides the software clear of irq_flag,
  // and the one-shot EN auto-clear yields to a same-cycle CTRL write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= RESET_PRESET;
      count    <= 32'd0;
      irq_flag <= 1'b0;
`ifdef CP0_TIMER_PRESCALE_EN
      prescale <= 8'd0;
      pcnt     <= 8'd0;
`endif
    end else begin
      if (ctrl_wr)
        {im, mode, en} <= bus.din[3:0];
      if (preset_wr)
        preset <= bus.din;
`ifdef CP0_TIMER_PRESCALE_EN
      if (bus.we && (bus.addr == 2'd3))
        prescale <= bus.din[7:0];
`endif
      if (ctrl_wr || preset_wr)
        irq_flag <= 1'b0;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
`ifdef CP0_TIMER_PRESCALE_EN
          pcnt  <= 8'd0;
`endif
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else begin
`ifdef CP0_TIMER_PRESCALE_EN
            pcnt <= step ? 8'd0 : pcnt + 8'd1;
`endif
            if (step) begin
              if (count > 32'd1) begin
                count <= count - 32'd1;
              end else begin
                count    <= 32'd0;
                irq_flag <= 1'b1;
                state    <= INT;
              end
            end
          end
        end
        INT: begin
          state <= IDLE;
          // Reserved MODE encodings (1x) behave as one-shot.
          if (mode == 2'b01)
            irq_flag <= 1'b0;
          else if (!ctrl_wr)
            en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      2'd0: bus.dout = {28'd0, im, mode, en};
      2'd1: bus.dout = preset;
      2'd2: bus.dout = count;
`ifdef CP0_TIMER_PRESCALE_EN
      2'd3: bus.dout = {24'd0, prescale};
`endif
      default: bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag & im;

endmodule

// File: tb/tb_cp0_timer.sv
// Directed self-checking bench for cp0_timer: reset, one-shot, periodic, disable,
// PRESET=0, reset mid-count, PRESET mid-run, and the addr3 prescaler register.
module tb_cp0_timer;
  localparam logic [31:0] RP = 32'h0000_00A5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cp0_timer_if bus();

  cp0_timer #(.RESET_PRESET(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    rd(2'd0, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_ctrl got %h exp %h", d, 32'd0); end
    rd(2'd1, d); tests++;
    if (d !== RP) begin fails++; $display("FAIL reset_preset got %h exp %h", d, RP); end
    rd(2'd2, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_count got %h exp %h", d, 32'd0); end
    tests++;
    if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    bus.addr = 2'd2;
    for (int i = 1; i <= 7; i++) begin
      tick();
      tests++;
      if (bus.irq !== (i == 7)) begin fails++; $display("FAIL oneshot_irq edge %0d got %b exp %b", i, bus.irq, (i == 7)); end
      if (i >= 2) begin
        tests++;
        if (bus.dout !== 32'(7 - i)) begin fails++; $display("FAIL oneshot_count edge %0d got %0d exp %0d", i, bus.dout, 7 - i); end
      end
    end
    tick(); tick();
    rd(2'd0, d); tests++;
    if (d !== 32'h8) begin fails++; $display("FAIL oneshot_ctrl_after got %h exp 8", d); end
    tests++;
    if (bus.irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq_hold got %b exp 1", bus.irq); end
    wr(2'd0, 32'h8);
    tests++;
    if (bus.irq !== 1'b0) begin fails++; $display("FAIL oneshot_irq_clear got %b exp 0", bus.irq); end
  endtask

  task automatic test_periodic();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 24; i++) begin
      tick();
      tests++;
      if (bus.irq !== (i == 7 || i == 15 || i == 23)) begin
        fails++; $display("FAIL periodic_irq edge %0d got %b", i, bus.irq);
      end
    end
    wr(2'd0, 32'h0);
    repeat (4) tick();
    // IM=0: counter keeps cycling with period 8, irq stays low
    wr(2'd0, 32'h3);
    bus.addr = 2'd2;
    for (int i = 1; i <= 24; i++) begin
      tick();
      tests++;
      if (bus.irq !== 1'b0) begin fails++; $display("FAIL periodic_masked_irq edge %0d got %b exp 0", i, bus.irq); end
      if (i == 10 || i == 18) begin
        tests++;
        if (bus.dout !== 32'd5) begin fails++; $display("FAIL periodic_masked_reload edge %0d got %0d exp 5", i, bus.dout); end
      end
      if (i == 15) begin
        tests++;
        if (bus.dout !== 32'd0) begin fails++; $display("FAIL periodic_masked_expire got %0d exp 0", bus.dout); end
      end
    end
    wr(2'd0, 32'h0);
    repeat (4) tick();
  endtask

  task automatic test_disable();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    bus.addr = 2'd2;
    repeat (5) tick();
    tests++;
    if (bus.dout !== 32'd7) begin fails++; $display("FAIL disable_pre got %0d exp 7", bus.dout); end
    // This write edge still decrements to 6; the next CNT cycle sees EN=0
    wr(2'd0, 32'h8);
    bus.addr = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (bus.dout !== 32'd6 || bus.irq !== 1'b0) begin
        fails++; $display("FAIL disable_frozen count %0d irq %b exp 6/0", bus.dout, bus.irq);
      end
    end
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    bus.addr = 2'd2;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests++;
      if (bus.irq !== (i == 5)) begin fails++; $display("FAIL disable_reload_irq edge %0d got %b exp %b", i, bus.irq, (i == 5)); end
      if (i == 2) begin
        tests++;
        if (bus.dout !== 32'd3) begin fails++; $display("FAIL disable_reload_count got %0d exp 3", bus.dout); end
      end
    end
  endtask

  task automatic test_preset0();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 16; i++) begin
      tick();
      tests++;
      if (bus.irq !== (i % 4 == 3)) begin fails++; $display("FAIL preset0_irq edge %0d got %b exp %b", i, bus.irq, (i % 4 == 3)); end
    end
    wr(2'd0, 32'h0);
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    bus.addr = 2'd2;
    repeat (5) tick();
    tests++;
    if (bus.dout !== 32'd2) begin fails++; $display("FAIL resetmid_pre got %0d exp 2", bus.dout); end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (bus.irq !== 1'b0 || bus.dout !== 32'd0) begin
        fails++; $display("FAIL resetmid_idle irq %b count %0d exp 0/0", bus.irq, bus.dout);
      end
    end
    rd(2'd0, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL resetmid_ctrl got %h exp 0", d); end
    rd(2'd1, d); tests++;
    if (d !== RP) begin fails++; $display("FAIL resetmid_preset got %h exp %h", d, RP); end
  endtask

  task automatic test_preset_midrun();
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    wr(2'd1, 32'd20);
    for (int i = 5; i <= 7; i++) begin
      tick();
      tests++;
      if (bus.irq !== (i == 7)) begin fails++; $display("FAIL midrun_irq edge %0d got %b exp %b", i, bus.irq, (i == 7)); end
    end
    tick();
    rd(2'd1, d); tests++;
    if (d !== 32'd20) begin fails++; $display("FAIL midrun_preset got %0d exp 20", d); end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    wr(2'd3, 32'h103);
`ifdef CP0_TIMER_PRESCALE_EN
    rd(2'd3, d); tests++;
    if (d !== 32'd3) begin fails++; $display("FAIL prescale_rd got %0d exp 3", d); end
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    bus.addr = 2'd2;
    for (int i = 1; i <= 10; i++) begin
      tick();
      tests++;
      if (bus.irq !== (i == 10)) begin fails++; $display("FAIL prescale_irq edge %0d got %b exp %b", i, bus.irq, (i == 10)); end
      if (i >= 2 && i <= 9) begin
        tests++;
        if (bus.dout !== ((i <= 5) ? 32'd2 : 32'd1)) begin
          fails++; $display("FAIL prescale_count edge %0d got %0d", i, bus.dout);
        end
      end
    end
`else
    rd(2'd3, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL addr3_rd got %0d exp 0", d); end
`endif
  endtask

  initial begin
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.din  = 32'd0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_disable();
    test_preset0();
    test_reset_mid();
    test_preset_midrun();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cp0_timer.md
Name: cp0_timer

Overview:
- Programmable countdown timer peripheral for the P7 MIPS pipeline.
- Sits directly upstream of the coprocessor-0 exception unit. Its `irq` output drives one bit of CP0's 6-bit HWInt vector.
- CPU access is via the system bridge: word-addressed register reads and writes from the MEM stage.
- Supports one-shot and periodic modes, with a software-maskable interrupt.

Parameters:
- `RESET_PRESET`, 32'd0, reset value of the PRESET register.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `addr` input 2: word offset within the timer (0=CTRL, 1=PRESET, 2=COUNT, 3=PRESCALE).
- `we` input 1: write enable from the bridge; sampled at the posedge.
- `din` input 32: write data.
- `dout` output 32: combinational read data for `addr`.
- `irq` output 1: interrupt request to CP0 HWInt.

Behaviour:
- Reset: CTRL=0, PRESET=`RESET_PRESET`, COUNT=0, PRESCALE=0, internal `irq_flag`=0, state=IDLE. Consequently `irq`=0 and `dout` reflects the reset registers.
- CTRL register fields:
  - bit0 EN: enable.
  - bits[2:1] MODE: 00 one-shot, 01 periodic, 1x reserved and treated as one-shot.
  - bit3 IM: interrupt mask; 1 = allow.
  - bits[31:4] read as 0.
- Writes (`we`=1 at posedge):
  - addr0 loads CTRL[3:0] from `din[3:0]`.
  - addr1 loads PRESET.
  - addr2 is ignored; COUNT is read-only.
  - Any write to addr0 or addr1 clears `irq_flag`.
- Reads, combinational:
  - addr0 → {28'b0, CTRL[3:0]}.
  - addr1 → PRESET.
  - addr2 → COUNT.
  - addr3 → see Optional Feature.
- `irq` = `irq_flag` & CTRL.IM, purely combinational from registers.
- FSM states and transitions:
  - IDLE: if CTRL.EN=1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If CTRL.EN=0, go to IDLE with COUNT held.
    - Else if COUNT>1, COUNT <= COUNT-1.
    - Else (COUNT is 1 or 0): COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT:
    - One-shot: CTRL.EN <= 0; `irq_flag` holds until the next CTRL/PRESET write or reset; go to IDLE.
    - Periodic: `irq_flag` <= 0 at the exit edge, so `irq` is exactly a 1-cycle pulse; go to IDLE. Since EN is still 1, the timer reloads.
- Timing:
  - From the edge that writes EN=1 with PRESET=N≥1, `irq_flag` rises at the (N+2)th following posedge.
  - Periodic period is N+3 cycles (4 cycles when N=0).
- PRESET written mid-count does not affect COUNT until the next LOAD.
- Simultaneous events:
  - Software CTRL write in the same cycle as the INT-state EN clear: the software write wins and `irq_flag` is still cleared.
  - Software write clearing `irq_flag` in the same cycle as CNT→INT sets it: the set wins.
- `reset` overrides everything in any state. Reset mid-count returns to IDLE with all registers at their reset values.
- COUNT decrements never wrap; 0 is the floor.

Optional Feature:
- Macro: `CP0_TIMER_PRESCALE_EN`.
- Defined:
  - Adds an 8-bit PRESCALE register at addr3: read returns {24'b0, PRESCALE}; write loads `din[7:0]`.
  - Adds an internal 8-bit `pcnt`, cleared in LOAD.
  - In CNT, the decrement/expiry step fires only when `pcnt`==PRESCALE, and `pcnt` resets to 0 on that cycle; otherwise `pcnt` increments.
  - The CNT step therefore advances every PRESCALE+1 cycles. PRESCALE=0 gives identical behaviour to the undefined case.
- Undefined: addr3 reads 0, writes are ignored, and the step fires every cycle.

Test Plan:
- Reset check: assert reset for 2 cycles, then read addr0/1/2 → 0, `RESET_PRESET`, 0; `irq`=0.
- One-shot: write PRESET=5, then CTRL=0x9 → `irq` rises 7 posedges after the CTRL write. COUNT reads 5,4,3,2,1,0. CTRL then reads 0x8 and `irq` stays 1; a subsequent write of CTRL=0x8 drops `irq` the next cycle.
- Periodic: PRESET=5, CTRL=0xB → `irq` is a 1-cycle pulse every 8 cycles for at least 3 periods. With CTRL=0x3 (IM=0), `irq` stays 0 while COUNT still cycles.
- Disable mid-count: one-shot with PRESET=10; at COUNT=6 write CTRL=0x8 → COUNT frozen at 6, no `irq`. Write PRESET=3 then CTRL=0x9 → reload to 3, and `irq` arrives 5 posedges later.
- Edge cases:
  - PRESET=0 periodic → pulse every 4 cycles.
  - Reset asserted at COUNT=2 → `irq` never rises and the state returns to IDLE.
  - PRESET write during CNT → the current run is unaffected.
- With `CP0_TIMER_PRESCALE_EN`: PRESCALE=3, PRESET=2, one-shot → COUNT holds each value 4 cycles. Read addr3 → 3.
